// File: rtl/ring_meter_pkg.sv
// Shared types and defaults for the ring oscillator frequency meter.
// Holds the measurement state encoding and the timer sizing helper.
package ring_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_GATE,
      ST_DONE
   } meter_state_t;

   localparam int DEF_GATE_CYCLES   = 256;
   localparam int DEF_SETTLE_CYCLES = 4;
   localparam int DEF_CW            = 16;
   localparam int DEF_SYNC_STAGES   = 2;

   // One timer serves both windows, so size it for the longer one; never below 1 bit.
   function automatic int timer_width(input int gate_cycles, input int settle_cycles);
      int longest;
      longest = (gate_cycles > settle_cycles) ? gate_cycles : settle_cycles;
      return ($clog2(longest) < 1) ? 1 : $clog2(longest);
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises an asynchronous test-structure output into CLK and flags its rising edges.
// EDGE is high for exactly one CLK cycle per synchronised low-to-high transition.
module sync_edge_det
   import ring_meter_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic CLK,
   input  logic RSTN,
   input  logic VDD,
   input  logic VSS,
   input  logic D,
   output logic EDGE
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // Runs in every state so an edge straddling a window boundary is seen once.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], D};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign EDGE = sync_q[SYNC_STAGES-1] & ~hist_q & VDD & ~VSS;

endmodule

// File: rtl/ring_freq_meter.sv
// Reader for a gated NAND ring oscillator: enables the ring, waits a settle window,
// then counts synchronised ring edges over a fixed CLK gate window.
module ring_freq_meter
   import ring_meter_pkg::*;
#(
   parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int CW            = DEF_CW,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic          CLK,
   input  logic          RSTN,
   input  logic          VDD,
   input  logic          VSS,
   input  logic          START,
   input  logic          OSC,
   output logic          EN,
   output logic          BUSY,
   output logic          DONE,
   output logic          OVF,
   output logic [CW-1:0] COUNT
);

   localparam int           TW          = timer_width(GATE_CYCLES, SETTLE_CYCLES);
   localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);
   localparam logic [CW-1:0] COUNT_MAX   = '1;

   meter_state_t  state, next_state;
   logic [TW-1:0] timer;
   logic          osc_edge;
   logic          start_ok;
   logic          en_dec;
   logic          power_good;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .CLK (CLK),
      .RSTN(RSTN),
      .VDD (VDD),
      .VSS (VSS),
      .D   (OSC),
      .EDGE(osc_edge)
   );

   assign power_good = VDD & ~VSS;
   assign start_ok   = START && (state == ST_IDLE || state == ST_DONE);

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE, ST_DONE: if (START)        next_state = ST_SETTLE;
         ST_SETTLE:        if (timer == '0) next_state = ST_GATE;
         ST_GATE:          if (timer == '0) next_state = ST_DONE;
         default:                            next_state = ST_IDLE;
      endcase
   end

   // Outputs decode straight from the state register, so reset drops EN without a clock.
   always_comb begin
      en_dec = (state == ST_SETTLE) || (state == ST_GATE);
      BUSY   = en_dec;
      DONE   = (state == ST_DONE);
      EN     = en_dec & power_good;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         timer <= '0;
      end else if (start_ok) begin
         timer <= SETTLE_LOAD;
      end else if (state == ST_SETTLE) begin
         timer <= (timer == '0) ? GATE_LOAD : timer - 1'b1;
      end else if (state == ST_GATE && timer != '0) begin
         timer <= timer - 1'b1;
      end
   end

   // Saturating edge counter; OVF latches once an edge arrives with the count already full.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         COUNT <= '0;
         OVF   <= 1'b0;
      end else if (start_ok) begin
         COUNT <= '0;
         OVF   <= 1'b0;
      end else if (state == ST_GATE && osc_edge) begin
         if (COUNT == COUNT_MAX) OVF   <= 1'b1;
         else                    COUNT <= COUNT + 1'b1;
      end
   end

endmodule
